// File: rtl/la_pkg.sv
// Shared constants and the capture-buffer state type for the logic-analyzer path.
package la_pkg;

  localparam int LA_DATA_W    = 128;
  localparam int LA_NUM_TEAMS = 13;
  localparam int LA_SEL_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } la_cap_state_t;

endpackage

// File: rtl/la_sample_ram.sv
// Sample storage: one synchronous write port and one asynchronous read port,
// so the reader sees the entry at its pointer in the same cycle.
module la_sample_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write one sample per enabled clock; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/la_capture_buffer.sv
// Logic-analyzer capture buffer: arm, wait for a masked-match trigger, record a
// burst of consecutive samples, then drain them over a valid/ready port.
// A team-select change while waiting or capturing abandons the capture.
module la_capture_buffer
  import la_pkg::*;
#(
  parameter int DATA_W = LA_DATA_W,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = LA_SEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        la_dat,
  input  logic [SEL_W-1:0]         la_sel,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [DATA_W-1:0]        trig_val,
  input  logic [$clog2(DEPTH):0]   num_samples,
  output logic [DATA_W-1:0]        rd_dat,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  la_cap_state_t     state_q, state_d;
  logic [CW-1:0]     target_q, target_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  // count_q doubles as the write pointer: samples are written densely from 0.
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic              wr_en;
  logic              trig_hit;
  logic              sel_changed;
  logic              rd_fire;
  logic [DATA_W-1:0] ram_rd_dat;

  la_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (la_dat),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (ram_rd_dat)
  );

  assign trig_hit    = ((la_dat ^ trig_val) & trig_mask) == '0;
  assign sel_changed = (la_sel != sel_q);
  assign rd_valid    = (state_q == DRAIN) && (rd_ptr_q < count_q);
  assign rd_dat      = rd_valid ? ram_rd_dat : '0;
  assign rd_fire     = rd_valid && rd_ready;
  assign busy        = (state_q != IDLE);
  assign state_o     = state_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

  // Next-state, pointer and write-enable logic for the capture sequence.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sel_d     = sel_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          // Zero or oversize requests fill the whole buffer.
          if ((num_samples == '0) || (num_samples > CW'(DEPTH))) begin
            target_d = CW'(DEPTH);
          end else begin
            target_d = num_samples;
          end
          sel_d    = la_sel;
          count_d  = '0;
          rd_ptr_d = '0;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (sel_changed) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (trig_hit) begin
          wr_en   = 1'b1;
          count_d = CW'(1);
          state_d = (target_q == CW'(1)) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (sel_changed) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          if (count_d == target_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rd_fire) begin
          rd_ptr_d = rd_ptr_q + CW'(1);
          if (rd_ptr_d == count_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      sel_q     <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_la_capture_buffer.sv
// Self-checking bench for la_capture_buffer: a queue-level behavioural model
// predicts every output each cycle, plus directed scenarios with literal checks.
module tb_la_capture_buffer;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int SW    = 4;
  localparam int CW    = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  la_dat;
  logic [SW-1:0]  la_sel;
  logic           arm;
  logic [DW-1:0]  trig_mask;
  logic [DW-1:0]  trig_val;
  logic [CW-1:0]  num_samples;
  logic [DW-1:0]  rd_dat;
  logic           rd_valid;
  logic           rd_ready;
  logic           busy;
  logic           done;
  logic           aborted;
  logic [1:0]     state_o;

  always #5 clk = ~clk;

  la_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .la_dat      (la_dat),
    .la_sel      (la_sel),
    .arm         (arm),
    .trig_mask   (trig_mask),
    .trig_val    (trig_val),
    .num_samples (num_samples),
    .rd_dat      (rd_dat),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .state_o     (state_o)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 draining.
  // Captured words live in a queue; a read pops the head.
  int            m_phase = 0;
  int            m_rem   = 0;
  logic [SW-1:0] m_sel   = '0;
  logic [DW-1:0] m_q[$];
  bit            m_done  = 1'b0;
  bit            m_abort = 1'b0;

  always @(posedge clk) begin
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_q.delete();
    end else if (m_phase == 0) begin
      if (arm) begin
        m_rem   = (num_samples == 0 || int'(num_samples) > DEPTH) ? DEPTH : int'(num_samples);
        m_sel   = la_sel;
        m_q.delete();
        m_phase = 1;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (la_sel != m_sel) begin
        m_abort = 1'b1;
        m_q.delete();
        m_phase = 0;
      end else if (m_phase == 2 || ((la_dat ^ trig_val) & trig_mask) == '0) begin
        m_q.push_back(la_dat);
        m_rem--;
        m_phase = (m_rem == 0) ? 3 : 2;
      end
    end else begin
      if (m_q.size() > 0 && rd_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_phase = 0;
          m_done  = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, outputs against the model; also logs transfers.
  bit            chk_en = 1'b0;
  logic [DW-1:0] rx[$];
  int            n_done = 0;
  int            n_abort = 0;
  int            n_valid = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic          exp_valid;
      logic [DW-1:0] exp_dat;
      exp_valid = (m_phase == 3) && (m_q.size() > 0);
      exp_dat   = exp_valid ? m_q[0] : '0;
      chk("state_o", DW'(state_o), DW'(m_phase));
      chk("busy", DW'(busy), DW'(m_phase != 0));
      chk("rd_valid", DW'(rd_valid), DW'(exp_valid));
      chk("rd_dat", rd_dat, exp_dat);
      chk("done", DW'(done), DW'(m_done));
      chk("aborted", DW'(aborted), DW'(m_abort));
      if (prev_stall) begin
        chk("stall_hold", rd_dat, prev_dat);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_dat   = rd_dat;
      if (rd_valid && rd_ready) rx.push_back(rd_dat);
      if (done) n_done++;
      if (aborted) n_abort++;
      if (rd_valid) n_valid++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    rx.delete();
    n_done  = 0;
    n_abort = 0;
    n_valid = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      la_dat = rand128();
      cyc();
      n++;
    end
    chk("idle_timeout", DW'(busy), DW'(0));
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] w[4];
  logic [DW-1:0] a5_word;
  logic [DW-1:0] wa;
  logic [DW-1:0] wb;

  initial begin
    rst = 1'b1; la_dat = '0; la_sel = 4'd3; arm = 1'b0;
    trig_mask = '0; trig_val = '0; num_samples = '0; rd_ready = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset_state", DW'(state_o), DW'(0));
    chk("reset_busy", DW'(busy), DW'(0));
    chk("reset_valid", DW'(rd_valid), DW'(0));
    chk("reset_done", DW'(done), DW'(0));
    rst = 1'b0;

    // 1: immediate trigger, 4 samples read back in order.
    clear_log();
    for (int i = 0; i < 4; i++) w[i] = {32'hC0DE0000 + 32'(i), 96'h1234_5678_9ABC_DEF0_0F1E_2D3C};
    num_samples = 5'd4; arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin la_dat = w[i]; cyc(); end
    wait_idle(100);
    chk("t1_count", DW'(rx.size()), DW'(4));
    for (int i = 0; i < 4 && i < rx.size(); i++) chk("t1_word", rx[i], w[i]);
    chk("t1_done", DW'(n_done), DW'(1));
    $display("txn t1: read %0d samples", rx.size());

    // 2: masked trigger on low byte A5 after five non-matching words.
    clear_log();
    trig_mask = 128'hFF; trig_val = 128'hA5;
    num_samples = 5'd3; la_dat = {rand128() >> 8, 8'h00}; arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 5; i++) begin la_dat = {rand128() >> 8, 8'h00}; cyc(); end
    a5_word = {rand128() >> 8, 8'hA5};
    la_dat = a5_word; cyc();
    wait_idle(100);
    chk("t2_count", DW'(rx.size()), DW'(3));
    if (rx.size() > 0) chk("t2_first", rx[0], a5_word);
    $display("txn t2: read %0d samples", rx.size());

    // 3: num_samples=0 clamps to full depth.
    clear_log();
    trig_mask = '0; num_samples = 5'd0; arm = 1'b1; cyc(); arm = 1'b0;
    wait_idle(100);
    chk("t3_count", DW'(rx.size()), DW'(16));
    chk("t3_state", DW'(state_o), DW'(0));
    chk("t3_valid", DW'(rd_valid), DW'(0));
    chk("t3_done", DW'(n_done), DW'(1));
    $display("txn t3: read %0d samples", rx.size());

    // 4: team select change mid-capture aborts.
    clear_log();
    la_sel = 4'd3; num_samples = 5'd8; arm = 1'b1; cyc(); arm = 1'b0;
    la_dat = rand128(); cyc();
    la_dat = rand128(); cyc();
    la_sel = 4'd7; cyc();
    cyc(); cyc();
    chk("t4_aborted", DW'(n_abort), DW'(1));
    chk("t4_valid", DW'(n_valid), DW'(0));
    chk("t4_busy", DW'(busy), DW'(0));
    $display("txn t4: aborted pulses %0d", n_abort);

    // 5: ready toggling in DRAIN and arm pulses during DRAIN.
    clear_log();
    num_samples = 5'd6; arm = 1'b1; cyc(); arm = 1'b0;
    for (int n = 0; n < 100 && busy; n++) begin
      la_dat = rand128();
      rd_ready = 1'($urandom_range(0, 1));
      arm = (state_o == 2'd3) ? 1'($urandom_range(0, 1)) : 1'b0;
      num_samples = 5'($urandom_range(1, 16));
      cyc();
    end
    arm = 1'b0; rd_ready = 1'b1;
    wait_idle(10);
    chk("t5_count", DW'(rx.size()), DW'(6));
    chk("t5_done", DW'(n_done), DW'(1));
    $display("txn t5: read %0d samples", rx.size());

    // 6: reset mid-capture, then a clean capture.
    num_samples = 5'd10; arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin la_dat = rand128(); cyc(); end
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_state", DW'(state_o), DW'(0));
    chk("t6_valid", DW'(rd_valid), DW'(0));
    chk("t6_busy", DW'(busy), DW'(0));
    clear_log();
    wa = rand128(); wb = rand128();
    num_samples = 5'd2; arm = 1'b1; cyc(); arm = 1'b0;
    la_dat = wa; cyc();
    la_dat = wb; cyc();
    wait_idle(20);
    chk("t6_count", DW'(rx.size()), DW'(2));
    if (rx.size() == 2) begin
      chk("t6_w0", rx[0], wa);
      chk("t6_w1", rx[1], wb);
    end
    $display("txn t6: read %0d samples", rx.size());

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      int n;
      clear_log();
      num_samples = 5'($urandom_range(0, 31));
      trig_mask = ($urandom_range(0, 2) == 0) ? '0 : (DW'(3) << $urandom_range(0, 120));
      trig_val = rand128();
      arm = 1'b1; cyc(); arm = 1'b0;
      n = 0;
      while (busy && n < 300) begin
        la_dat = rand128();
        rd_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 59) == 0) la_sel = 4'($urandom_range(0, 12));
        if (n == 50) trig_mask = '0;
        cyc();
        n++;
      end
      chk("rnd_timeout", DW'(busy), DW'(0));
      rd_ready = 1'b1;
      cyc();
      $display("txn r%0d: read %0d aborted %0d done %0d", t, rx.size(), n_abort, n_done);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
